// File: rtl/alu_pkg.sv
// Shared opcode constants and issue-stage FSM encoding.
// Used by the ALU, the issue stage and their benches.
package alu_pkg;

   localparam int OP_WIDTH = 4;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_NAND = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_XNOR = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // Opcodes at or above numOps never reach the ALU result path.
   function automatic logic isLegalOp(input logic [3:0] op, input int numOps);
      return (int'(op) < numOps);
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-drive and result handshake bundle for the ALU issue stage.
// The slave modport is the issue stage; master is whoever feeds and drains it.
interface alu_issue_stage_if #(
   parameter int WIDTH = 16
);
   import alu_pkg::*;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [WIDTH-1:0]        cmd_a;
   logic [WIDTH-1:0]        cmd_b;
   logic [OP_WIDTH-1:0]     cmd_op;

   logic [WIDTH-1:0]        alu_a;
   logic [WIDTH-1:0]        alu_b;
   logic [OP_WIDTH-1:0]     alu_op_select;
   logic [2*WIDTH-1:0]      alu_result;

   logic                    res_valid;
   logic                    res_ready;
   logic [2*WIDTH-1:0]      res_data;
   logic                    res_err;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op_select, res_valid, res_data, res_err
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op_select, res_valid, res_data, res_err
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue stage: {op, a, b} entries, wrapping pointers.
// Head entry is visible combinationally on o_data whenever o_empty is low.
module alu_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [2*WIDTH+3:0]         i_data,
   input  logic                       i_pop,
   output logic [2*WIDTH+3:0]         o_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2*WIDTH + 4;

   logic [EW-1:0]  r_mem [DEPTH];
   logic [AW-1:0]  r_wrPtr;
   logic [AW-1:0]  r_rdPtr;
   logic [AW:0]    r_count;
   logic           w_doPush;
   logic           w_doPop;

   assign o_full   = (r_count == (AW+1)'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;
   assign o_data   = r_mem[r_rdPtr];
   assign o_count  = r_count;

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers commands, drives a downstream ALU one command at a
// time and holds each result until the consumer takes it.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NUM_OPS = 8,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_issue_stage_if.slave           io,
   output logic [$clog2(DEPTH):0]     o_fifo_count,
   output logic                       o_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2*WIDTH + 4;

   state_t               r_state;
   logic [WIDTH-1:0]     r_aluA;
   logic [WIDTH-1:0]     r_aluB;
   logic [OP_WIDTH-1:0]  r_aluOp;
   logic                 r_resValid;
   logic [2*WIDTH-1:0]   r_resData;
   logic                 r_resErr;

   logic                 w_cmdReady;
   logic                 w_push;
   logic                 w_pop;
   logic [EW-1:0]        w_pushData;
   logic [EW-1:0]        w_head;
   logic [AW:0]          w_count;
   logic                 w_full;
   logic                 w_empty;
   logic [OP_WIDTH-1:0]  w_headOp;
   logic [WIDTH-1:0]     w_headA;
   logic [WIDTH-1:0]     w_headB;

   // Ready looks only at occupancy so it never combinationally depends on a pop.
   assign w_cmdReady = (w_count != (AW+1)'(DEPTH));
   assign w_push     = io.cmd_valid && w_cmdReady;
   assign w_pushData = {io.cmd_op, io.cmd_a, io.cmd_b};

   assign w_pop = !w_empty &&
                  ((r_state == ST_IDLE) ||
                   ((r_state == ST_RESULT) && io.res_ready));

   assign w_headOp = w_head[EW-1 -: OP_WIDTH];
   assign w_headA  = w_head[WIDTH +: WIDTH];
   assign w_headB  = w_head[WIDTH-1:0];

   alu_cmd_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_pushData),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // One cycle in ISSUE lets the ALU settle on the freshly registered operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_aluA     <= '0;
         r_aluB     <= '0;
         r_aluOp    <= '0;
         r_resValid <= 1'b0;
         r_resData  <= '0;
         r_resErr   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_aluA  <= w_headA;
                  r_aluB  <= w_headB;
                  r_aluOp <= w_headOp;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (isLegalOp(r_aluOp, NUM_OPS)) begin
                  r_resData <= io.alu_result;
                  r_resErr  <= 1'b0;
               end else begin
                  r_resData <= '0;
                  r_resErr  <= 1'b1;
               end
               r_resValid <= 1'b1;
               r_state    <= ST_RESULT;
            end
            ST_RESULT: begin
               // The held result is consumed here, so valid drops either way.
               if (io.res_ready) begin
                  r_resValid <= 1'b0;
                  if (w_pop) begin
                     r_aluA  <= w_headA;
                     r_aluB  <= w_headB;
                     r_aluOp <= w_headOp;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io.cmd_ready     = w_cmdReady;
   assign io.alu_a         = r_aluA;
   assign io.alu_b         = r_aluB;
   assign io.alu_op_select = r_aluOp;
   assign io.res_valid     = r_resValid;
   assign io.res_data      = r_resData;
   assign io.res_err       = r_resErr;
   assign o_fifo_count     = w_count;
   assign o_busy           = (r_state != ST_IDLE) || !w_empty;

   logic w_unusedFull;
   assign w_unusedFull = w_full;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small 16-bit ALU model attached
// to the alu_* drive; expected values are hand-computed constants.
module tb_alu_issue_stage;
   import alu_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   logic [$clog2(DEPTH):0] fifoCount;
   logic busy;
   int checks;
   int errors;

   alu_issue_stage_if #(.WIDTH(WIDTH)) bus ();

   alu_issue_stage #(
      .WIDTH   (WIDTH),
      .NUM_OPS (8),
      .DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .io           (bus),
      .o_fifo_count (fifoCount),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: 16-bit logic ops zero-extended, ADD keeps its carry.
   logic [16:0] aluSum;
   always_comb begin
      aluSum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      case (bus.alu_op_select)
         ALU_ADD:  bus.alu_result = {15'd0, aluSum};
         ALU_SUB:  bus.alu_result = {16'd0, bus.alu_a - bus.alu_b};
         ALU_AND:  bus.alu_result = {16'd0, bus.alu_a & bus.alu_b};
         ALU_OR:   bus.alu_result = {16'd0, bus.alu_a | bus.alu_b};
         ALU_NAND: bus.alu_result = {16'd0, ~(bus.alu_a & bus.alu_b)};
         ALU_NOR:  bus.alu_result = {16'd0, ~(bus.alu_a | bus.alu_b)};
         ALU_XOR:  bus.alu_result = {16'd0, bus.alu_a ^ bus.alu_b};
         ALU_XNOR: bus.alu_result = {16'd0, ~(bus.alu_a ^ bus.alu_b)};
         default:  bus.alu_result = 32'hDEAD_BEEF;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offers one command for exactly one rising edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   logic [3:0]  burstOp  [5];
   logic [15:0] burstA   [5];
   logic [15:0] burstB   [5];
   logic [31:0] burstExp [5];

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a = '0;
      bus.cmd_b = '0;
      bus.cmd_op = '0;
      bus.res_ready = 1'b0;

      burstOp[0] = ALU_ADD;  burstA[0] = 16'hFFFF; burstB[0] = 16'hFFFF; burstExp[0] = 32'h0001_FFFE;
      burstOp[1] = ALU_OR;   burstA[1] = 16'h1200; burstB[1] = 16'h0034; burstExp[1] = 32'h0000_1234;
      burstOp[2] = ALU_AND;  burstA[2] = 16'hF0F0; burstB[2] = 16'h0FF0; burstExp[2] = 32'h0000_00F0;
      burstOp[3] = ALU_NOR;  burstA[3] = 16'h0F0F; burstB[3] = 16'h00F0; burstExp[3] = 32'h0000_F000;
      burstOp[4] = ALU_XNOR; burstA[4] = 16'h1234; burstB[4] = 16'h1234; burstExp[4] = 32'h0000_FFFF;

      // Reset before any clock edge, then held across edges.
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_count", 64'(fifoCount), 64'd0);
      checkOutput("rst_res_valid", 64'(bus.res_valid), 64'd0);
      checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_alu_a", 64'(bus.alu_a), 64'd0);
      checkOutput("rst_res_data", 64'(bus.res_data), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

      // Single ADD: alu_* after E1, result after E2.
      bus.res_ready = 1'b1;
      applyStimulus(ALU_ADD, 16'h0005, 16'h0003);
      checkOutput("add_e0_count", 64'(fifoCount), 64'd1);
      checkOutput("add_e0_busy", 64'(busy), 64'd1);
      checkOutput("add_e0_res_valid", 64'(bus.res_valid), 64'd0);
      tick();
      checkOutput("add_e1_alu_a", 64'(bus.alu_a), 64'h5);
      checkOutput("add_e1_alu_b", 64'(bus.alu_b), 64'h3);
      checkOutput("add_e1_alu_op", 64'(bus.alu_op_select), 64'(ALU_ADD));
      checkOutput("add_e1_res_valid", 64'(bus.res_valid), 64'd0);
      tick();
      checkOutput("add_e2_res_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("add_e2_res_data", 64'(bus.res_data), 64'h0000_0008);
      checkOutput("add_e2_res_err", 64'(bus.res_err), 64'd0);
      tick();
      checkOutput("add_e3_res_valid", 64'(bus.res_valid), 64'd0);
      checkOutput("add_e3_busy", 64'(busy), 64'd0);
      checkOutput("add_hold_alu_a", 64'(bus.alu_a), 64'h5);

      // Back-to-back SUB, NAND, XOR: one result every two cycles.
      bus.cmd_valid = 1'b1;
      bus.cmd_op = ALU_SUB;  bus.cmd_a = 16'h0005; bus.cmd_b = 16'h0003;
      tick();
      bus.cmd_op = ALU_NAND; bus.cmd_a = 16'hFFFF; bus.cmd_b = 16'h00FF;
      tick();
      bus.cmd_op = ALU_XOR;  bus.cmd_a = 16'hAAAA; bus.cmd_b = 16'h5555;
      tick();
      bus.cmd_valid = 1'b0;
      checkOutput("b2b_sub_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("b2b_sub_data", 64'(bus.res_data), 64'h0000_0002);
      tick();
      checkOutput("b2b_gap1_valid", 64'(bus.res_valid), 64'd0);
      tick();
      checkOutput("b2b_nand_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("b2b_nand_data", 64'(bus.res_data), 64'h0000_FF00);
      tick();
      checkOutput("b2b_gap2_valid", 64'(bus.res_valid), 64'd0);
      tick();
      checkOutput("b2b_xor_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("b2b_xor_data", 64'(bus.res_data), 64'h0000_FFFF);
      tick();
      checkOutput("b2b_end_valid", 64'(bus.res_valid), 64'd0);

      // Stalled consumer: five commands fill one in-flight slot plus the FIFO.
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.cmd_op = burstOp[i];
         bus.cmd_a  = burstA[i];
         bus.cmd_b  = burstB[i];
         tick();
      end
      checkOutput("full_count", 64'(fifoCount), 64'd4);
      checkOutput("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      checkOutput("full_res_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("full_res_data", 64'(bus.res_data), 64'(burstExp[0]));
      bus.cmd_op = ALU_ADD; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0001;
      tick();
      tick();
      bus.cmd_valid = 1'b0;
      checkOutput("full_no_push_count", 64'(fifoCount), 64'd4);
      checkOutput("stall_res_data", 64'(bus.res_data), 64'(burstExp[0]));
      checkOutput("stall_res_valid", 64'(bus.res_valid), 64'd1);
      bus.res_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         checkOutput($sformatf("drain%0d_gap", i), 64'(bus.res_valid), 64'd0);
         tick();
         checkOutput($sformatf("drain%0d_valid", i), 64'(bus.res_valid), 64'd1);
         checkOutput($sformatf("drain%0d_data", i), 64'(bus.res_data), 64'(burstExp[i]));
      end
      tick();
      checkOutput("drain_end_valid", 64'(bus.res_valid), 64'd0);
      checkOutput("drain_end_busy", 64'(busy), 64'd0);
      checkOutput("drain_end_count", 64'(fifoCount), 64'd0);

      // Illegal opcode zeroes data and flags error; next legal clears it.
      applyStimulus(4'b1000, 16'h0001, 16'h0002);
      tick();
      checkOutput("ill_alu_op", 64'(bus.alu_op_select), 64'h8);
      tick();
      checkOutput("ill_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("ill_err", 64'(bus.res_err), 64'd1);
      checkOutput("ill_data", 64'(bus.res_data), 64'd0);
      tick();
      applyStimulus(ALU_ADD, 16'h0001, 16'h0001);
      tick();
      tick();
      checkOutput("legal_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("legal_err", 64'(bus.res_err), 64'd0);
      checkOutput("legal_data", 64'(bus.res_data), 64'h0000_0002);
      tick();

      // Reset mid-cycle with a pending result and two queued commands.
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = ALU_XOR; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0003;
      tick();
      bus.cmd_op = ALU_OR;  bus.cmd_a = 16'h0010; bus.cmd_b = 16'h0001;
      tick();
      bus.cmd_op = ALU_SUB; bus.cmd_a = 16'h0009; bus.cmd_b = 16'h0004;
      tick();
      bus.cmd_valid = 1'b0;
      checkOutput("pre_rst_valid", 64'(bus.res_valid), 64'd1);
      checkOutput("pre_rst_count", 64'(fifoCount), 64'd2);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_valid", 64'(bus.res_valid), 64'd0);
      checkOutput("arst_count", 64'(fifoCount), 64'd0);
      checkOutput("arst_alu_a", 64'(bus.alu_a), 64'd0);
      checkOutput("arst_alu_b", 64'(bus.alu_b), 64'd0);
      checkOutput("arst_alu_op", 64'(bus.alu_op_select), 64'd0);
      checkOutput("arst_res_data", 64'(bus.res_data), 64'd0);
      checkOutput("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("arst_busy", 64'(busy), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("post_arst%0d_valid", i), 64'(bus.res_valid), 64'd0);
         checkOutput($sformatf("post_arst%0d_busy", i), 64'(busy), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
